// File: rtl/prf_read_stage.sv
// Physical register file with a one-entry operand-read stage between issue and execute.
// Captured operands see same-cycle writeback and are refreshed while the stage stalls.
module prf_read_stage #(
   parameter int XLEN      = 64,
   parameter int NUM_PREGS = 64,
   parameter int TAG_W     = 8,
   localparam int PREG_W   = $clog2(NUM_PREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [PREG_W-1:0] wr_addr,
   input  logic [XLEN-1:0]   wr_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PREG_W-1:0] in_rs1,
   input  logic [PREG_W-1:0] in_rs2,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_rs1_data,
   output logic [XLEN-1:0]   out_rs2_data,
   output logic [TAG_W-1:0]  out_tag
);

   logic [XLEN-1:0]   regs_r [NUM_PREGS];
   logic [PREG_W-1:0] src1_r;
   logic [PREG_W-1:0] src2_r;
   logic              accept_s;
   logic              wr_live_s;
   logic [XLEN-1:0]   rs1_val_s;
   logic [XLEN-1:0]   rs2_val_s;

   // Handshake and operand selection: preg 0 reads zero, a same-cycle write bypasses the array.
   always_comb begin
      in_ready  = !out_valid || out_ready;
      accept_s  = in_valid && in_ready;
      wr_live_s = wr_en && (wr_addr != {PREG_W{1'b0}});
      rs1_val_s = {XLEN{1'b0}};
      rs2_val_s = {XLEN{1'b0}};
      if (in_rs1 == {PREG_W{1'b0}}) begin
         rs1_val_s = {XLEN{1'b0}};
      end else if (wr_en && (wr_addr == in_rs1)) begin
         rs1_val_s = wr_data;
      end else begin
         rs1_val_s = regs_r[in_rs1];
      end
      if (in_rs2 == {PREG_W{1'b0}}) begin
         rs2_val_s = {XLEN{1'b0}};
      end else if (wr_en && (wr_addr == in_rs2)) begin
         rs2_val_s = wr_data;
      end else begin
         rs2_val_s = regs_r[in_rs2];
      end
   end

   // Register file storage; entry 0 is never written so it stays zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < NUM_PREGS; k++) begin
            regs_r[k] <= {XLEN{1'b0}};
         end
      end else if (wr_live_s) begin
         regs_r[wr_addr] <= wr_data;
      end else begin
         regs_r[0] <= {XLEN{1'b0}};
      end
   end

   // Output bundle: capture on accept, drop on bare consume, otherwise hold with refresh.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         out_rs1_data <= {XLEN{1'b0}};
         out_rs2_data <= {XLEN{1'b0}};
         out_tag      <= {TAG_W{1'b0}};
         src1_r       <= {PREG_W{1'b0}};
         src2_r       <= {PREG_W{1'b0}};
      end else if (accept_s) begin
         out_valid    <= 1'b1;
         out_rs1_data <= rs1_val_s;
         out_rs2_data <= rs2_val_s;
         out_tag      <= in_tag;
         src1_r       <= in_rs1;
         src2_r       <= in_rs2;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end else if (out_valid && wr_live_s) begin
         // Stalled bundle tracks writeback so execute never sees a stale source.
         if (wr_addr == src1_r) begin
            out_rs1_data <= wr_data;
         end else begin
            out_rs1_data <= out_rs1_data;
         end
         if (wr_addr == src2_r) begin
            out_rs2_data <= wr_data;
         end else begin
            out_rs2_data <= out_rs2_data;
         end
      end else begin
         out_valid <= out_valid;
      end
   end

endmodule

// File: tb/tb_prf_read_stage.sv
// Self-checking bench for prf_read_stage: directed scenarios plus randomized traffic
// compared against an array-based behavioural model.
module tb_prf_read_stage;
   localparam int XLEN = 64;
   localparam int NP   = 64;
   localparam int TW   = 8;
   localparam int PW   = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [PW-1:0] wr_addr;
   logic [XLEN-1:0] wr_data;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_rs1;
   logic [PW-1:0] in_rs2;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [XLEN-1:0] out_rs1_data;
   logic [XLEN-1:0] out_rs2_data;
   logic [TW-1:0] out_tag;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state
   logic [XLEN-1:0] m_regs [NP];
   logic            m_valid;
   logic [XLEN-1:0] m_d1, m_d2;
   logic [TW-1:0]   m_tag;
   logic [PW-1:0]   m_s1, m_s2;

   prf_read_stage #(.XLEN(XLEN), .NUM_PREGS(NP), .TAG_W(TW)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] model_read(input logic [PW-1:0] a);
      if (a == 0) return '0;
      if (wr_en && wr_addr == a) return wr_data;
      return m_regs[a];
   endfunction

   // Advance one clock, updating the model from the inputs present at the edge.
   task automatic tick();
      logic acc, rst, we;
      logic [PW-1:0] wa, r1, r2;
      logic [XLEN-1:0] wd, v1, v2;
      logic [TW-1:0] tg;
      rst = !reset; we = wr_en; wa = wr_addr; wd = wr_data;
      r1 = in_rs1; r2 = in_rs2; tg = in_tag;
      acc = in_valid && (!m_valid || out_ready);
      v1 = model_read(r1);
      v2 = model_read(r2);
      @(posedge clk);
      #1;
      if (rst) begin
         for (int k = 0; k < NP; k++) m_regs[k] = '0;
         m_valid = 0; m_d1 = '0; m_d2 = '0; m_tag = '0; m_s1 = '0; m_s2 = '0;
      end else begin
         if (acc) begin
            m_valid = 1; m_d1 = v1; m_d2 = v2; m_tag = tg; m_s1 = r1; m_s2 = r2;
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end else if (m_valid && we && wa != 0) begin
            if (wa == m_s1) m_d1 = wd;
            if (wa == m_s2) m_d2 = wd;
         end
         if (we && wa != 0) m_regs[wa] = wd;
      end
   endtask

   task automatic idle();
      wr_en = 0; wr_addr = '0; wr_data = '0;
      in_valid = 0; in_rs1 = '0; in_rs2 = '0; in_tag = '0; out_ready = 1;
   endtask

   task automatic test_reset();
      idle();
      reset = 0; wr_en = 1; wr_addr = 6'd5; wr_data = 64'hAA;
      tick(); tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out_rs1_data !== 64'd0 || out_rs2_data !== 64'd0 || out_tag !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%0b d1=%h d2=%h tag=%h required 0/0/0/0",
                  out_valid, out_rs1_data, out_rs2_data, out_tag);
      end
      idle(); reset = 1;
      in_valid = 1; in_rs1 = 6'd5; in_rs2 = 6'd0; in_tag = 8'h01;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_rs1_data !== 64'd0 || out_rs2_data !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_read: valid=%0b d1=%h d2=%h required 1/0/0",
                  out_valid, out_rs1_data, out_rs2_data);
      end
      idle(); tick();
   endtask

   task automatic test_write_read();
      idle();
      wr_en = 1; wr_addr = 6'd7; wr_data = 64'h1234;
      tick();
      idle();
      in_valid = 1; in_rs1 = 6'd7; in_rs2 = 6'd7; in_tag = 8'h3C;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_rs1_data !== 64'h1234 || out_rs2_data !== 64'h1234 || out_tag !== 8'h3C) begin
         n_fail++;
         $display("FAIL write_read: valid=%0b d1=%h d2=%h tag=%h required 1/1234/1234/3c",
                  out_valid, out_rs1_data, out_rs2_data, out_tag);
      end
      idle(); tick();
   endtask

   task automatic test_bypass();
      idle();
      wr_en = 1; wr_addr = 6'd9; wr_data = 64'h11;
      tick();
      wr_en = 1; wr_addr = 6'd9; wr_data = 64'h22;
      in_valid = 1; in_rs1 = 6'd9; in_rs2 = 6'd0; in_tag = 8'h05;
      tick();
      n_cmp++;
      if (out_rs1_data !== 64'h22 || out_rs2_data !== 64'd0) begin
         n_fail++;
         $display("FAIL bypass: d1=%h d2=%h required 22/0", out_rs1_data, out_rs2_data);
      end
      wr_en = 1; wr_addr = 6'd0; wr_data = 64'hFF;
      in_valid = 1; in_rs1 = 6'd9; in_rs2 = 6'd0; in_tag = 8'h06;
      tick();
      n_cmp++;
      if (out_rs2_data !== 64'd0 || out_rs1_data !== 64'h22) begin
         n_fail++;
         $display("FAIL preg0_write: d1=%h d2=%h required 22/0", out_rs1_data, out_rs2_data);
      end
      idle(); tick();
   endtask

   task automatic test_stall_refresh();
      idle();
      wr_en = 1; wr_addr = 6'd4; wr_data = 64'h1;
      tick();
      idle(); out_ready = 0;
      in_valid = 1; in_rs1 = 6'd4; in_rs2 = 6'd3; in_tag = 8'h44;
      tick();
      wr_en = 1; wr_addr = 6'd4; wr_data = 64'h99;
      in_valid = 1; in_rs1 = 6'd1; in_rs2 = 6'd2; in_tag = 8'h55;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_ready: in_ready=%0b required 0", in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_rs1_data !== 64'h99 || out_tag !== 8'h44) begin
         n_fail++;
         $display("FAIL stall_refresh: valid=%0b d1=%h tag=%h required 1/99/44",
                  out_valid, out_rs1_data, out_tag);
      end
      idle(); tick();
   endtask

   task automatic test_back_to_back();
      idle();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in_tag = TW'(i);
         in_rs1 = PW'(i); in_rs2 = PW'(i + 1);
         #1;
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready[%0d]: in_ready=%0b required 1", i, in_ready);
         end
         tick();
         n_cmp++;
         if (out_valid !== 1'b1 || out_tag !== TW'(i)) begin
            n_fail++;
            $display("FAIL b2b_tag[%0d]: valid=%0b tag=%0d required 1/%0d", i, out_valid, out_tag, i);
         end
      end
      idle(); tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         wr_en = ($urandom_range(0, 3) != 0);
         wr_addr = PW'($urandom_range(0, 7));
         wr_data = {$urandom, $urandom};
         in_valid = ($urandom_range(0, 2) != 0);
         in_rs1 = PW'($urandom_range(0, 7));
         in_rs2 = PW'($urandom_range(0, 7));
         in_tag = TW'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         n_cmp++;
         if (in_ready !== (!m_valid || out_ready)) begin
            n_fail++;
            $display("FAIL rand_ready[%0d]: in_ready=%0b required %0b", c, in_ready, (!m_valid || out_ready));
         end
         tick();
         n_cmp++;
         if (out_valid !== m_valid ||
             (m_valid && (out_rs1_data !== m_d1 || out_rs2_data !== m_d2 || out_tag !== m_tag))) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: valid=%0b d1=%h d2=%h tag=%h required %0b/%h/%h/%h",
                     c, out_valid, out_rs1_data, out_rs2_data, out_tag, m_valid, m_d1, m_d2, m_tag);
         end
      end
      idle(); tick();
   endtask

   task automatic test_reset_midstall();
      idle();
      wr_en = 1; wr_addr = 6'd12; wr_data = 64'hDEAD;
      tick();
      idle(); out_ready = 0;
      in_valid = 1; in_rs1 = 6'd12; in_rs2 = 6'd12; in_tag = 8'h77;
      tick();
      idle(); out_ready = 0; reset = 0;
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out_rs1_data !== 64'd0 || out_rs2_data !== 64'd0 || out_tag !== 8'd0) begin
         n_fail++;
         $display("FAIL midstall_reset: valid=%0b d1=%h d2=%h tag=%h required 0/0/0/0",
                  out_valid, out_rs1_data, out_rs2_data, out_tag);
      end
      reset = 1; out_ready = 1;
      in_valid = 1; in_rs1 = 6'd12; in_rs2 = 6'd7; in_tag = 8'h78;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_rs1_data !== 64'd0 || out_rs2_data !== 64'd0) begin
         n_fail++;
         $display("FAIL midstall_readback: valid=%0b d1=%h d2=%h required 1/0/0",
                  out_valid, out_rs1_data, out_rs2_data);
      end
      idle(); tick();
   endtask

   initial begin
      for (int k = 0; k < NP; k++) m_regs[k] = '0;
      m_valid = 0; m_d1 = '0; m_d2 = '0; m_tag = '0; m_s1 = '0; m_s2 = '0;
      reset = 0;
      idle();
      #1;
      test_reset();
      test_write_read();
      test_bypass();
      test_stall_refresh();
      test_back_to_back();
      test_random();
      test_reset_midstall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
